// File: rtl/chan_mux_scan_if.sv
// Bus bundle for chan_mux_scan: the packed channel inputs and the registered selection results.
// The master drives the channels and controls, and the slave (the mux) returns results plus debug state.
interface chan_mux_scan_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] data_in;
  logic [SELW-1:0]      sel;
  logic                 mode;
  logic                 hold;

  // valid has no ready partner. It rises on the first non-held cycle after reset.
  // From then on, data_out/chan_out always carry a sampled value, and it only returns to 0 on reset.
  logic [WIDTH-1:0]     data_out;
  logic [SELW-1:0]      chan_out;
  logic                 valid;
  logic                 wrap;
  logic                 err;

  logic                 dbg_scan;
  logic [SELW-1:0]      dbg_idx;
  logic [7:0]           dbg_cnt;

  modport master (
    output data_in, sel, mode, hold,
    input  data_out, chan_out, valid, wrap, err, dbg_scan, dbg_idx, dbg_cnt
  );

  modport slave (
    input  data_in, sel, mode, hold,
    output data_out, chan_out, valid, wrap, err, dbg_scan, dbg_idx, dbg_cnt
  );
endinterface

// File: rtl/chan_mux_scan.sv
// Registered N-channel mux with two modes: a manual select mode and an auto-scan mode with a programmable dwell.
// All outputs are flops; the mode history restarts the scan at channel 0 whenever auto-scan is (re)entered.
module chan_mux_scan #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int DWELL = 8
) (
  input  logic            clock,
  input  logic            resetn,
  chan_mux_scan_if.slave  bus
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNTW = 8;
  localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] IDX_LAST   = SELW'(NCH - 1);

  typedef enum logic {ST_MANUAL = 1'b0, ST_SCAN = 1'b1} state_t;

  state_t          state_q;
  logic [SELW-1:0] idx_q;
  logic [CNTW-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0] chan_q;
  logic            valid_q;
  logic            wrap_q;
  logic            err_q;

  logic            restart;
  logic [SELW-1:0] cur_idx;
  logic [CNTW-1:0] cur_cnt;
  logic [WIDTH-1:0] man_data;
  logic [WIDTH-1:0] scan_data;
  logic            sel_ok;

  always_comb begin
    restart   = (state_q == ST_MANUAL);
    cur_idx   = restart ? '0 : idx_q;
    cur_cnt   = restart ? '0 : cnt_q;
    sel_ok    = (int'(bus.sel) < NCH);
    man_data  = '0;
    scan_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (bus.sel == SELW'(k)) man_data  = bus.data_in[k*WIDTH +: WIDTH];
      if (cur_idx == SELW'(k)) scan_data = bus.data_in[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_MANUAL;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.hold) begin
      wrap_q <= 1'b0;
    end else if (!bus.mode) begin
      state_q <= ST_MANUAL;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= man_data;
      chan_q  <= bus.sel;
      valid_q <= 1'b1;
      wrap_q  <= 1'b0;
      err_q   <= !sel_ok;
    end else begin
      state_q <= ST_SCAN;
      data_q  <= scan_data;
      chan_q  <= cur_idx;
      valid_q <= 1'b1;
      err_q   <= 1'b0;
      // While scanning, the only way to hold index 0 with a zero count is a wrap from NCH-1.
      wrap_q  <= !restart && (idx_q == '0) && (cnt_q == '0);
      if (cur_cnt == DWELL_LAST) begin
        cnt_q <= '0;
        idx_q <= (cur_idx == IDX_LAST) ? '0 : cur_idx + 1'b1;
      end else begin
        cnt_q <= cur_cnt + 1'b1;
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.chan_out = chan_q;
  assign bus.valid    = valid_q;
  assign bus.wrap     = wrap_q;
  assign bus.err      = err_q;
  assign bus.dbg_scan = (state_q == ST_SCAN);
  assign bus.dbg_idx  = idx_q;
  assign bus.dbg_cnt  = cnt_q;
endmodule

// File: doc/chan_mux_scan.md
CHAN_MUX_SCAN -- requirements
Module: chan_mux_scan

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each data channel.
REQ-002 Parameter NCH, default 4: channel count, legal range 2..16.
REQ-003 Parameter DWELL, default 8: cycles spent on each channel in scan mode, legal range 1..255.
REQ-004 Derived SELW = max(1, ceil(log2(NCH))): select and channel-index width.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 resetn  input  1  synchronous, active-low reset, sampled on rising clock edge.
REQ-007 data_in  input  NCH*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SELW  channel select used in manual mode.
REQ-009 mode  input  1  0 = manual select, 1 = auto-scan.
REQ-010 hold  input  1  1 = freeze all registered state except reset.
REQ-011 data_out  output  WIDTH  registered selected channel data.
REQ-012 chan_out  output  SELW  registered index of the channel driving data_out.
REQ-013 valid  output  1  high once data_out carries a sampled value.
REQ-014 wrap  output  1  one-cycle pulse when scan index wraps NCH-1 -> 0.
REQ-015 err  output  1  registered flag: manual sel >= NCH on the last sampled cycle.

Function
REQ-016 All outputs SHALL be registered; latency from data_in/sel to data_out/chan_out is exactly 1 cycle.
REQ-017 Manual (mode=0, hold=0), sel < NCH: data_out <= channel sel, chan_out <= sel, err <= 0, valid <= 1.
REQ-018 Manual, sel >= NCH: data_out <= 0, chan_out <= sel, err <= 1, valid <= 1.
REQ-019 Scan (mode=1, hold=0): internal scan index and dwell counter drive selection; data_out <= channel[scan index], chan_out <= scan index, err <= 0, valid <= 1 every cycle.
REQ-020 Dwell counter counts 0..DWELL-1; scan index advances by 1 on the cycle the counter is DWELL-1, and the counter returns to 0.
REQ-021 Advance from NCH-1 SHALL wrap to 0 and assert wrap for exactly that one cycle; wrap is 0 in all other cycles and whenever mode=0.
REQ-022 DWELL=1: index advances every cycle; consecutive wraps every NCH cycles.
REQ-023 Manual-to-scan transition (mode 0 in cycle n-1, 1 in cycle n): scan index and dwell counter SHALL restart at 0, so channel 0 is output after cycle n.
REQ-024 Scan-to-manual transition: manual rule applies immediately in that cycle; scan state is discarded.
REQ-025 hold=1: data_out, chan_out, valid, err, scan index and dwell counter SHALL keep their values; wrap SHALL be 0.
REQ-026 hold=1 together with a mode change: the change is not registered; mode history is updated only on cycles with hold=0, so the restart of REQ-023 occurs on the first hold=0 cycle with mode=1 after manual.
REQ-027 Only channel data is sampled; no combinational path from any input to any output.

Reset
REQ-028 resetn=0 at a rising edge SHALL set data_out=0, chan_out=0, valid=0, wrap=0, err=0, scan index=0, dwell counter=0, mode history=manual.
REQ-029 Reset has priority over hold and mode, including mid-dwell and mid-scan.
REQ-030 valid SHALL stay 0 after reset until the first rising edge with resetn=1 and hold=0.

Verification (WIDTH=4, NCH=4, DWELL=3 unless stated)
REQ-031 Manual: data_in=16'hD5A3, sel=2 -> one cycle later data_out=4'h5, chan_out=2, err=0, valid=1.
REQ-032 Manual out-of-range, NCH=3 (SELW=2), sel=3 -> data_out=0, err=1; next sel=0 -> err=0, data_out=channel 0.
REQ-033 Scan from reset: mode=1 for 12 cycles -> chan_out sequence 0,0,0,1,1,1,2,2,2,3,3,3, then 0 with wrap=1 on that cycle only.
REQ-034 Hold: scan, assert hold on the 2nd cycle of channel 1 for 5 cycles -> outputs frozen, wrap=0; after release channel 1 persists 1 more cycle, then 2.
REQ-035 Reset mid-scan at chan_out=2 -> next cycle all outputs 0, valid=0; resumes from channel 0.
REQ-036 DWELL=1, NCH=2: mode=1 -> chan_out alternates 0,1,0,1; wrap=1 on every cycle chan_out returns to 0.
